// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - memory-mapped 8-bit UART with TX/RX FIFOs, threshold interrupts and W1C error flags
// Optional UART_PARITY_EN adds register 0x20 PARITY ([0] enable, [1] odd) and a parity bit per frame.

module uart_fifo_mem_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic [8:0] count,
  output logic       drop
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, empty, do_pop, do_push;

  assign full    = (count == 9'(DEPTH));
  assign empty   = (count == 9'd0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + 9'(do_push) - 9'(do_pop);
    end
  end
endmodule

module uart_fifo_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int RESET_BAUD = 434
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [3:0]            be,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  irq,
  output logic                  bus_err,
  output logic                  tx_pin,
  input  logic                  rx_pin
);
`ifdef UART_PARITY_EN
  localparam logic [6:0] LIMIT = 7'h20;
`else
  localparam logic [6:0] LIMIT = 7'h1C;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_t;

  logic [15:0] div, div_eff;
  logic [2:0]  int_en, pend, w1c;
  logic [7:0]  thresh, thresh_eff, status;
  logic [1:0]  par_cfg;
  logic        rx_ovr, tx_ovf, par_err, tx_empty_d, par_evt;

  logic [8:0]  tx_count, rx_count;
  logic [7:0]  tx_dout, rx_dout, rx_byte;
  logic        tx_pop, tx_drop, rx_push, rx_pop, rx_drop, tx_push;
  logic        tx_empty_st, tx_full, rx_hit;

  logic [5:0]  off;
  logic [3:0]  reg_sel;
  logic [1:0]  sz;
  logic        be_ok, acc, acc_err, wr_ok, rd_ok;
  logic [6:0]  last;
  logic [15:0] rd_word, rd_sh, rd_val;
  logic        unused_bits;

  function automatic logic [7:0] lvl8(input logic [8:0] c);
    return c[8] ? 8'hFF : c[7:0];
  endfunction

  assign unused_bits = ^i_data[DATA_WIDTH-1:16];

  // ---------------- bus decode ----------------
  assign off     = addr[5:0];
  assign reg_sel = off[5:2];

  always_comb begin
    sz    = 2'd0;
    be_ok = 1'b1;
    case (be)
      4'b0001: sz = 2'd0;
      4'b0011: sz = 2'd1;
      4'b1111: sz = 2'd2;
      default: be_ok = 1'b0;
    endcase
  end

  assign last    = {1'b0, off} + ((sz == 2'd2) ? 7'd3 : (sz == 2'd1) ? 7'd1 : 7'd0);
  assign acc_err = ~be_ok | ((sz == 2'd1) & off[0]) | ((sz == 2'd2) & (off[1:0] != 2'b00)) |
                   (|addr[ADDR_WIDTH-1:6]) | ({1'b0, off} > LIMIT) | (last > LIMIT + 7'd3);
  assign acc     = enable & ~ready;
  // Sub-word writes above lane 0 only touch reserved bits and are ignored.
  assign wr_ok   = acc & ~acc_err & wr_en & (off[1:0] == 2'b00);
  assign rd_ok   = acc & ~acc_err & ~wr_en;
  assign w1c     = (wr_ok && reg_sel == 4'd5) ? i_data[2:0] : 3'b000;
  assign tx_push = wr_ok && reg_sel == 4'd3;
  assign rx_pop  = rd_ok && reg_sel == 4'd3 && off[1:0] == 2'b00;

  assign tx_full    = (tx_count == 9'(FIFO_DEPTH));
  assign thresh_eff = (thresh == 8'd0) ? 8'd1 : thresh;
  assign rx_hit     = (rx_count >= {1'b0, thresh_eff});
  assign status     = {2'b00, par_err, tx_ovf, rx_ovr, tx_full, tx_empty_st, (rx_count != 9'd0)};
  assign irq        = |(pend & int_en);

  always_comb begin
    rd_word = 16'h0000;
    case (reg_sel)
      4'd0: rd_word = div;
      4'd1: rd_word = {8'h00, div[15:8]};
      4'd2: rd_word = {8'h00, status};
      4'd3: rd_word = (rx_count != 9'd0) ? {8'h00, rx_dout} : 16'h0000;
      4'd4: rd_word = {13'h0000, int_en};
      4'd5: rd_word = {13'h0000, pend};
      4'd6: rd_word = {lvl8(tx_count), lvl8(rx_count)};
      4'd7: rd_word = {8'h00, thresh};
`ifdef UART_PARITY_EN
      4'd8: rd_word = {14'h0000, par_cfg};
`endif
      default: rd_word = 16'h0000;
    endcase
  end

  assign rd_sh  = rd_word >> {off[1:0], 3'b000};
  assign rd_val = (sz == 2'd0) ? {8'h00, rd_sh[7:0]} : rd_sh;

`ifndef UART_PARITY_EN
  assign par_cfg = 2'b00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready      <= 1'b0;
      bus_err    <= 1'b0;
      o_data     <= '0;
      div        <= 16'(RESET_BAUD);
      int_en     <= '0;
      pend       <= '0;
      thresh     <= 8'd1;
      rx_ovr     <= 1'b0;
      tx_ovf     <= 1'b0;
      par_err    <= 1'b0;
      tx_empty_d <= 1'b1;
`ifdef UART_PARITY_EN
      par_cfg    <= 2'b00;
`endif
    end else begin
      ready   <= acc;
      bus_err <= acc & acc_err;
      o_data  <= rd_ok ? {{(DATA_WIDTH-16){1'b0}}, rd_val} : '0;
      if (wr_ok) begin
        case (reg_sel)
          4'd0: begin
            div[7:0] <= i_data[7:0];
            if (sz != 2'd0) div[15:8] <= i_data[15:8];
          end
          4'd1: div[15:8] <= i_data[7:0];
          4'd4: int_en    <= i_data[2:0];
          4'd7: thresh    <= i_data[7:0];
`ifdef UART_PARITY_EN
          4'd8: par_cfg   <= i_data[1:0];
`endif
          default: ;
        endcase
      end
      // New events win over a simultaneous clear so nothing is lost.
      pend <= (pend & ~w1c) | {(rx_drop | tx_drop | par_evt), (tx_empty_st & ~tx_empty_d), rx_hit};
      tx_empty_d <= tx_empty_st;
      rx_ovr     <= (rx_ovr & ~w1c[2]) | rx_drop;
      tx_ovf     <= (tx_ovf & ~w1c[2]) | tx_drop;
      par_err    <= (par_err & ~w1c[2]) | par_evt;
    end
  end

  uart_fifo_mem_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(i_data[7:0]), .pop(tx_pop),
    .dout(tx_dout), .count(tx_count), .drop(tx_drop)
  );

  uart_fifo_mem_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_byte), .pop(rx_pop),
    .dout(rx_dout), .count(rx_count), .drop(rx_drop)
  );

  assign div_eff = (div < 16'd2) ? 16'd2 : div;

  // ---------------- transmitter ----------------
  uart_state_t tx_st;
  logic [15:0] tx_cnt, tx_div;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_par, tx_end;

  assign tx_end      = (tx_cnt == tx_div - 16'd1);
  assign tx_pop      = (tx_st == S_IDLE || (tx_st == S_STOP && tx_end)) && tx_count != 9'd0;
  assign tx_empty_st = (tx_count == 9'd0) && (tx_st == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st  <= S_IDLE;
      tx_pin <= 1'b1;
      tx_cnt <= '0;
      tx_div <= 16'd2;
      tx_bit <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_cnt <= tx_end ? 16'd0 : tx_cnt + 16'd1;
      if (tx_pop) begin
        tx_st  <= S_START;
        tx_pin <= 1'b0;
        tx_cnt <= '0;
        tx_div <= div_eff;
        tx_sh  <= tx_dout;
        tx_bit <= '0;
        tx_par <= ^tx_dout;
      end else begin
        case (tx_st)
          S_IDLE: tx_cnt <= '0;
          S_START: if (tx_end) begin
            tx_st  <= S_DATA;
            tx_pin <= tx_sh[0];
          end
          S_DATA: if (tx_end) begin
            if (tx_bit == 3'd7) begin
              tx_st  <= par_cfg[0] ? S_PARITY : S_STOP;
              tx_pin <= par_cfg[0] ? (tx_par ^ par_cfg[1]) : 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx_sh  <= tx_sh >> 1;
              tx_pin <= tx_sh[1];
            end
          end
          S_PARITY: if (tx_end) begin
            tx_st  <= S_STOP;
            tx_pin <= 1'b1;
          end
          S_STOP: if (tx_end) tx_st <= S_IDLE;
          default: tx_st <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  uart_state_t rx_st;
  logic [15:0] rx_cnt, rx_div;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_sh;
  logic        rx_meta, rx_s, rx_pbit, rx_end, rx_half;

  assign rx_end  = (rx_cnt == rx_div - 16'd1);
  assign rx_half = (rx_cnt == (rx_div >> 1) - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_st   <= S_IDLE;
      rx_cnt  <= '0;
      rx_div  <= 16'd2;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_pbit <= 1'b0;
      rx_push <= 1'b0;
      rx_byte <= '0;
      par_evt <= 1'b0;
    end else begin
      rx_meta <= rx_pin;
      rx_s    <= rx_meta;
      rx_push <= 1'b0;
      par_evt <= 1'b0;
      rx_cnt  <= rx_cnt + 16'd1;
      case (rx_st)
        S_IDLE: begin
          rx_cnt <= '0;
          if (!rx_s) begin
            rx_st  <= S_START;
            rx_div <= div_eff;
          end
        end
        // Start bit must still be low at mid-bit, otherwise it was a glitch.
        S_START: if (rx_half) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_st  <= rx_s ? S_IDLE : S_DATA;
        end
        S_DATA: if (rx_end) begin
          rx_cnt <= '0;
          rx_sh  <= {rx_s, rx_sh[7:1]};
          if (rx_bit == 3'd7) rx_st <= par_cfg[0] ? S_PARITY : S_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end
        S_PARITY: if (rx_end) begin
          rx_cnt  <= '0;
          rx_pbit <= rx_s;
          rx_st   <= S_STOP;
        end
        S_STOP: if (rx_end) begin
          rx_cnt <= '0;
          rx_st  <= S_IDLE;
          if (rx_s) begin
            rx_push <= 1'b1;
            rx_byte <= rx_sh;
            par_evt <= par_cfg[0] & (rx_pbit ^ (^rx_sh) ^ par_cfg[1]);
          end
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_mem.sv
// tb/tb_uart_fifo_mem.sv - directed loopback bench for uart_fifo_mem (FIFO_DEPTH=4, divider 434)
`timescale 1ns/1ps

module tb_uart_fifo_mem;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * 434;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] i_data = '0;
  logic [3:0]  be = '0;
  logic        ready, irq, bus_err, tx_pin, rx_pin;
  logic [31:0] o_data;
  logic [31:0] rd;
  logic        err;
  int          tests = 0;
  int          fails = 0;

  assign rx_pin = tx_pin;
  always #5 clk = ~clk;

  uart_fifo_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_BAUD(434)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .addr(addr),
    .i_data(i_data), .be(be), .ready(ready), .o_data(o_data), .irq(irq),
    .bus_err(bus_err), .tx_pin(tx_pin), .rx_pin(rx_pin)
  );

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    fails++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic bus(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    enable = 1'b1; wr_en = wr; addr = a; i_data = d; be = b;
    @(negedge clk);
    enable = 1'b0;
    tests++;
    if (ready !== 1'b1) fail("ready_pulse", ready, 1'b1);
    rd  = o_data;
    err = bus_err;
  endtask

  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic exp_err);
    bus(1'b1, a, d, b);
    tests++;
    if (err !== exp_err) fail({tag, "_err"}, err, exp_err);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] exp, input logic exp_err);
    bus(1'b0, a, 32'h0, b);
    tests++;
    if (rd !== exp) fail(tag, rd, exp);
    tests++;
    if (err !== exp_err) fail({tag, "_err"}, err, exp_err);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(3);
    tests++;
    if (ready !== 1'b0) fail("rst_ready", ready, 1'b0);
    tests++;
    if (bus_err !== 1'b0) fail("rst_bus_err", bus_err, 1'b0);
    tests++;
    if (o_data !== 32'h0) fail("rst_o_data", o_data, 32'h0);
    tests++;
    if (irq !== 1'b0) fail("rst_irq", irq, 1'b0);
    tests++;
    if (tx_pin !== 1'b1) fail("rst_tx_pin", tx_pin, 1'b1);
    rst_n = 1'b1;
    wait_cyc(2);
    rd_chk("rst_status", 32'h08, 4'b0011, 32'h0000_0002, 1'b0);
    rd_chk("rst_level", 32'h18, 4'b0011, 32'h0000_0000, 1'b0);
    rd_chk("rst_thresh", 32'h1C, 4'b0001, 32'h0000_0001, 1'b0);
    rd_chk("rst_baud", 32'h00, 4'b0011, 32'h0000_01B2, 1'b0);
    rd_chk("rst_int_en", 32'h10, 4'b1111, 32'h0000_0000, 1'b0);

    wr_chk("baud_h_wr", 32'h04, 32'h03, 4'b0001, 1'b0);
    rd_chk("baud_after_h", 32'h00, 4'b0011, 32'h0000_03B2, 1'b0);
    wr_chk("baud16_wr", 32'h00, 32'h01B2, 4'b0011, 1'b0);
    rd_chk("baud16_rd", 32'h00, 4'b0011, 32'h0000_01B2, 1'b0);
    rd_chk("baud_l_rd", 32'h00, 4'b0001, 32'h0000_00B2, 1'b0);
    rd_chk("baud_h_rd", 32'h04, 4'b0001, 32'h0000_0001, 1'b0);

    rd_chk("err_w_01", 32'h01, 4'b1111, 32'h0, 1'b1);
    rd_chk("err_w_02", 32'h02, 4'b1111, 32'h0, 1'b1);
    rd_chk("err_w_03", 32'h03, 4'b1111, 32'h0, 1'b1);
    rd_chk("err_h_01", 32'h01, 4'b0011, 32'h0, 1'b1);
    rd_chk("err_24", 32'h24, 4'b0001, 32'h0, 1'b1);
    rd_chk("err_20", 32'h20, 4'b1111, 32'h0, 1'b1);
    rd_chk("err_be0101", 32'h08, 4'b0101, 32'h0, 1'b1);
    rd_chk("err_upper", 32'h0000_0108, 4'b0001, 32'h0, 1'b1);
    wr_chk("err_wr_baud", 32'h01, 32'hFFFF, 4'b0011, 1'b1);
    wr_chk("err_wr_thr", 32'h1C, 32'h07, 4'b0101, 1'b1);
    rd_chk("baud_kept", 32'h00, 4'b0011, 32'h0000_01B2, 1'b0);
    rd_chk("thresh_kept", 32'h1C, 4'b0001, 32'h0000_0001, 1'b0);

    wr_chk("tx_11", 32'h0C, 32'h11, 4'b0001, 1'b0);
    wr_chk("tx_22", 32'h0C, 32'h22, 4'b0001, 1'b0);
    wr_chk("tx_33", 32'h0C, 32'h33, 4'b0001, 1'b0);
    wait_cyc(3 * FRAME + 50);
    rd_chk("lvl_3", 32'h18, 4'b0011, 32'h0000_0003, 1'b0);
    rd_chk("pop_11", 32'h0C, 4'b0001, 32'h11, 1'b0);
    rd_chk("pop_22", 32'h0C, 4'b0001, 32'h22, 1'b0);
    rd_chk("pop_33", 32'h0C, 4'b0001, 32'h33, 1'b0);
    rd_chk("pop_empty", 32'h0C, 4'b0001, 32'h00, 1'b0);
    rd_chk("status_drained", 32'h08, 4'b0001, 32'h02, 1'b0);
    tests++;
    if (irq !== 1'b0) fail("irq_masked", irq, 1'b0);

    wr_chk("w1c_all", 32'h14, 32'h7, 4'b0001, 1'b0);
    wr_chk("thr_2", 32'h1C, 32'h2, 4'b0001, 1'b0);
    wr_chk("inten_1", 32'h10, 32'h1, 4'b0001, 1'b0);
    tests++;
    if (irq !== 1'b0) fail("irq_armed_low", irq, 1'b0);
    wr_chk("tx_a5", 32'h0C, 32'hA5, 4'b0001, 1'b0);
    wait_cyc(FRAME + 100);
    tests++;
    if (irq !== 1'b0) fail("irq_one_byte", irq, 1'b0);
    wr_chk("tx_5a", 32'h0C, 32'h5A, 4'b0001, 1'b0);
    wait_cyc(FRAME + 100);
    tests++;
    if (irq !== 1'b1) fail("irq_two_bytes", irq, 1'b1);
    rd_chk("pend_3", 32'h14, 4'b0001, 32'h3, 1'b0);
    wr_chk("w1c_rx_held", 32'h14, 32'h1, 4'b0001, 1'b0);
    tests++;
    if (irq !== 1'b1) fail("irq_reasserts", irq, 1'b1);
    rd_chk("pop_a5", 32'h0C, 4'b0001, 32'hA5, 1'b0);
    wr_chk("w1c_rx_free", 32'h14, 32'h1, 4'b0001, 1'b0);
    tests++;
    if (irq !== 1'b0) fail("irq_cleared", irq, 1'b0);
    rd_chk("pend_2", 32'h14, 4'b0001, 32'h2, 1'b0);
    rd_chk("pop_5a", 32'h0C, 4'b0001, 32'h5A, 1'b0);
    wr_chk("inten_0", 32'h10, 32'h0, 4'b0001, 1'b0);
    wr_chk("thr_1", 32'h1C, 32'h1, 4'b0001, 1'b0);
    wr_chk("w1c_all2", 32'h14, 32'h7, 4'b0001, 1'b0);

    for (int i = 1; i <= DEPTH + 1; i++) wr_chk("tx_fill", 32'h0C, 32'(i), 4'b0001, 1'b0);
    wait_cyc((DEPTH + 1) * FRAME + 100);
    rd_chk("lvl_full", 32'h18, 4'b0011, 32'(DEPTH), 1'b0);
    rd_chk("status_ovr", 32'h08, 4'b0001, 32'h0B, 1'b0);
    rd_chk("pend_err", 32'h14, 4'b0001, 32'h7, 1'b0);
    wr_chk("w1c_err", 32'h14, 32'h4, 4'b0001, 1'b0);
    rd_chk("status_ovr_clr", 32'h08, 4'b0001, 32'h03, 1'b0);
    for (int i = 1; i <= DEPTH; i++) rd_chk("pop_fill", 32'h0C, 4'b0001, 32'(i), 1'b0);
    wr_chk("w1c_all3", 32'h14, 32'h7, 4'b0001, 1'b0);

    for (int i = 0; i < DEPTH + 2; i++) wr_chk("tx_ovf_wr", 32'h0C, 32'h55, 4'b0001, 1'b0);
    rd_chk("status_ovf", 32'h08, 4'b0001, 32'h14, 1'b0);
    rd_chk("lvl_tx_full", 32'h18, 4'b0011, 32'(DEPTH << 8), 1'b0);
    tests++;
    if (tx_pin !== 1'b0) fail("tx_pin_start", tx_pin, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (tx_pin !== 1'b1) fail("tx_pin_async", tx_pin, 1'b1);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    rd_chk("lvl_after_rst", 32'h18, 4'b0011, 32'h0, 1'b0);
    rd_chk("status_after_rst", 32'h08, 4'b0001, 32'h02, 1'b0);
    rd_chk("baud_after_rst", 32'h00, 4'b0011, 32'h0000_01B2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
